// File: rtl/ddr3_rd_burst_ctrl.sv
// DDR3 read-burst controller: issues 128-bit burst reads, buffers the returns and
// serializes them as 32-bit AXIS words for the fill-readout path.
//
// state     | meaning
// IDLE      | waiting for a rising edge of enable_reading
// ISSUE     | issuing bursts, credit-limited by outstanding count and buffer space
// WAIT_DATA | all bursts issued, draining returned data to AXIS
// DONE      | transfer complete, reading_done held until enable_reading falls
// FLUSH     | aborted, discarding returns of bursts still in flight
module ddr3_rd_burst_ctrl #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable_reading,
    input  logic [22:0]  ddr3_rd_start_addr,
    input  logic [23:0]  ddr3_rd_burst_cnt,
    output logic         reading_done,
    output logic         mem_rd_req,
    output logic [22:0]  mem_rd_addr,
    input  logic         mem_rd_ack,
    input  logic         mem_rd_data_valid,
    input  logic [127:0] mem_rd_data,
    output logic [31:0]  m_tdata,
    output logic         m_tvalid,
    output logic         m_tlast,
    input  logic         m_tready
);

    localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int OW1 = OW + 1;
    localparam int AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DATA = 3'd2,
        DONE      = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;

    logic           r_en_q;
    logic           r_en_d;
    logic [22:0]    r_addr;
    logic [23:0]    r_burst_cnt;
    logic [23:0]    r_issued;
    logic [23:0]    r_returned;
    logic [23:0]    r_popped;
    logic [OW-1:0]  r_outstanding;

    logic [127:0]   r_mem [MAX_OUTSTANDING];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [OW-1:0]  r_fcnt;

    logic [127:0]   r_out_data;
    logic           r_out_valid;
    logic           r_out_last;
    logic [1:0]     r_word_idx;

    logic           w_rise;
    logic           w_active;
    logic           w_abort;
    logic [OW1-1:0] w_inflight;
    logic           w_room;
    logic           w_req;
    logic           w_issue;
    logic           w_last_issue;
    logic           w_ret;
    logic           w_push;
    logic           w_beat;
    logic           w_pop;
    logic           w_tvalid;
    logic           w_tlast;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reset asserts asynchronously, releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_rise       = r_en_q & ~r_en_d;
    assign w_active     = (r_state == ISSUE) || (r_state == WAIT_DATA);
    assign w_abort      = w_active & ~enable_reading;

    // A burst may only be issued if its return is guaranteed a buffer slot.
    assign w_inflight   = OW1'(r_outstanding) + OW1'(r_fcnt);
    assign w_room       = w_inflight < OW1'(MAX_OUTSTANDING);
    assign w_req        = (r_state == ISSUE) && enable_reading &&
                          (r_issued != r_burst_cnt) && w_room;
    assign w_issue      = w_req & mem_rd_ack;
    assign w_last_issue = w_issue && ((r_issued + 24'd1) == r_burst_cnt);

    assign w_ret        = mem_rd_data_valid && (r_returned != r_issued);
    assign w_push       = w_ret && w_active && enable_reading;

    assign w_tvalid     = r_out_valid & enable_reading;
    assign w_tlast      = w_tvalid && r_out_last && (r_word_idx == 2'd3);
    assign w_beat       = w_tvalid & m_tready;
    assign w_pop        = w_active && enable_reading && (r_fcnt != '0) &&
                          (!r_out_valid || (w_beat && (r_word_idx == 2'd3)));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = (ddr3_rd_burst_cnt == 24'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!enable_reading) begin
                    w_state_nxt = FLUSH;
                end else if (w_last_issue) begin
                    w_state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!enable_reading) begin
                    w_state_nxt = FLUSH;
                end else if (w_beat && w_tlast) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!enable_reading) begin
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (r_outstanding == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_en_q        <= 1'b0;
            r_en_d        <= 1'b0;
            r_addr        <= '0;
            r_burst_cnt   <= '0;
            r_issued      <= '0;
            r_returned    <= '0;
            r_popped      <= '0;
            r_outstanding <= '0;
        end else begin
            r_en_q <= enable_reading;
            r_en_d <= r_en_q;
            if ((r_state == IDLE) && w_rise) begin
                r_addr      <= ddr3_rd_start_addr;
                r_burst_cnt <= ddr3_rd_burst_cnt;
                r_issued    <= '0;
                r_returned  <= '0;
                r_popped    <= '0;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + 23'd1;
                    r_issued <= r_issued + 24'd1;
                end
                if (w_ret) begin
                    r_returned <= r_returned + 24'd1;
                end
                if (w_pop) begin
                    r_popped <= r_popped + 24'd1;
                end
            end
            case ({w_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= mem_rd_data;
        end
    end

    // Holding register serializes one burst while the FIFO keeps receiving.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_word_idx  <= '0;
        end else if (w_abort) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_word_idx  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_pop) begin
                r_out_data  <= r_mem[r_rptr];
                r_out_valid <= 1'b1;
                r_out_last  <= ((r_popped + 24'd1) == r_burst_cnt);
                r_word_idx  <= '0;
            end else if (w_beat) begin
                r_word_idx <= r_word_idx + 2'd1;
                if (r_word_idx == 2'd3) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        m_tdata = r_out_data[31:0];
        case (r_word_idx)
            2'd0:    m_tdata = r_out_data[31:0];
            2'd1:    m_tdata = r_out_data[63:32];
            2'd2:    m_tdata = r_out_data[95:64];
            default: m_tdata = r_out_data[127:96];
        endcase
    end

    assign mem_rd_req   = w_req;
    assign mem_rd_addr  = r_addr;
    assign m_tvalid     = w_tvalid;
    assign m_tlast      = w_tlast;
    assign reading_done = (r_state == DONE);

endmodule

// File: tb/tb_ddr3_rd_burst_ctrl.sv
// Bench for ddr3_rd_burst_ctrl: randomized memory/AXIS environment, directed transfers,
// expected addresses and word stream computed from the transfer parameters.
module tb_ddr3_rd_burst_ctrl;

    localparam int MAXO = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable_reading;
    logic [22:0]  ddr3_rd_start_addr;
    logic [23:0]  ddr3_rd_burst_cnt;
    logic         reading_done;
    logic         mem_rd_req;
    logic [22:0]  mem_rd_addr;
    logic         mem_rd_ack = 1'b0;
    logic         mem_rd_data_valid = 1'b0;
    logic [127:0] mem_rd_data = '0;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int unsigned  cyc = 0;
    logic [127:0] pend_data[$];
    int unsigned  pend_due[$];
    logic [22:0]  iss_addr[$];
    logic [127:0] iss_data[$];
    logic [31:0]  cap_data[$];
    logic         cap_last[$];
    int ack_pct = 100, ret_delay = 1, tready_pct = 100;
    int ack_limit = 32'h3FFF_FFFF, ret_limit = 32'h3FFF_FFFF;
    int n_iss = 0, n_ret = 0, max_out = 0;
    bit done_seen = 1'b0;
    bit stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    ddr3_rd_burst_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n), .enable_reading(enable_reading),
        .ddr3_rd_start_addr(ddr3_rd_start_addr), .ddr3_rd_burst_cnt(ddr3_rd_burst_cnt),
        .reading_done(reading_done), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data_valid(mem_rd_data_valid),
        .mem_rd_data(mem_rd_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Environment drive, just after each rising edge: ack, in-order data return, tready.
    always begin
        @(posedge clk);
        #3;
        cyc++;
        mem_rd_ack = (n_iss < ack_limit) && ($urandom_range(99) < ack_pct);
        if (pend_due.size() != 0 && pend_due[0] <= cyc && n_ret < ret_limit) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = pend_data.pop_front();
            void'(pend_due.pop_front());
            n_ret++;
        end else begin
            mem_rd_data_valid = 1'b0;
            mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
        end
        m_tready = ($urandom_range(99) < tready_pct);
    end

    // Environment observe, just before each rising edge: handshakes about to complete.
    always begin
        logic [127:0] d;
        @(negedge clk);
        #3;
        if (mem_rd_req && mem_rd_ack) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            iss_addr.push_back(mem_rd_addr);
            iss_data.push_back(d);
            pend_data.push_back(d);
            pend_due.push_back(cyc + ret_delay);
            n_iss++;
        end
        if (n_iss - n_ret > max_out) max_out = n_iss - n_ret;
        if (m_tvalid && m_tready) begin
            cap_data.push_back(m_tdata);
            cap_last.push_back(m_tlast);
        end
        if (stall_prev && m_tvalid) chk("tdata_hold", m_tdata, stall_data);
        stall_prev = m_tvalid && !m_tready;
        stall_data = m_tdata;
        if (reading_done) done_seen = 1'b1;
    end

    task automatic wait_quiet(input string tag);
        int k = 0;
        while (pend_due.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_quiet"}, pend_due.size(), 0);
    endtask

    task automatic clear_env();
        iss_addr.delete(); iss_data.delete(); cap_data.delete(); cap_last.delete();
        n_iss = 0; n_ret = 0; max_out = 0; done_seen = 1'b0;
        ack_limit = 32'h3FFF_FFFF; ret_limit = 32'h3FFF_FFFF;
    endtask

    task automatic run_xfer(input string tag, input logic [22:0] start, input logic [23:0] cnt,
                            input int ackp, input int dly, input int trp, input int stall);
        int k;
        logic [22:0]  ea;
        logic [127:0] d;
        wait_quiet(tag);
        clear_env();
        ack_pct = ackp; ret_delay = dly; tready_pct = (stall > 0) ? 0 : trp;
        @(negedge clk);
        ddr3_rd_start_addr = start;
        ddr3_rd_burst_cnt  = cnt;
        enable_reading     = 1'b1;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            tready_pct = trp;
        end
        k = 0;
        while (!reading_done && k < 20000) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk({tag, "_done"}, reading_done, 1'b1);
        chk({tag, "_nburst"}, iss_addr.size(), cnt);
        chk({tag, "_maxout_ok"}, (max_out <= MAXO), 1'b1);
        ea = start;
        for (int i = 0; i < iss_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), iss_addr[i], ea);
            ea = ea + 23'd1;
        end
        chk({tag, "_nword"}, cap_data.size(), 4 * cnt);
        for (int i = 0; i < cap_data.size(); i++) begin
            d = (i / 4 < iss_data.size()) ? iss_data[i / 4] : 'x;
            chk($sformatf("%s_word%0d", tag, i), cap_data[i], d[32 * (i % 4) +: 32]);
            chk($sformatf("%s_last%0d", tag, i), cap_last[i], (i == 4 * cnt - 1));
        end
        @(negedge clk);
        enable_reading = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_done_clr"}, reading_done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ncap;
        reset_n = 1'b0;
        enable_reading = 1'b0;
        ddr3_rd_start_addr = '0;
        ddr3_rd_burst_cnt = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", mem_rd_req, 1'b0);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_done", reading_done, 1'b0);
        chk("rst_addr", mem_rd_addr, 23'd0);
        chk("rst_tdata", m_tdata, 32'd0);

        // Request already present as reset releases: must not start within 2 cycles.
        @(negedge clk);
        reset_n = 1'b1;
        enable_reading = 1'b1;
        @(negedge clk); #1;
        chk("rst_sync_c1", reading_done, 1'b0);
        @(negedge clk); #1;
        chk("rst_sync_c2", reading_done, 1'b0);
        k = 0;
        while (!reading_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_sync_done", reading_done, 1'b1);
        @(negedge clk);
        enable_reading = 1'b0;
        repeat (3) @(negedge clk);

        // Zero-length transfer timing.
        clear_env();
        @(negedge clk);
        ddr3_rd_start_addr = 23'h000040;
        ddr3_rd_burst_cnt = 24'd0;
        enable_reading = 1'b1;
        @(negedge clk); #1;
        chk("cnt0_done_c1", reading_done, 1'b0);
        @(negedge clk); #1;
        chk("cnt0_done_c2", reading_done, 1'b1);
        repeat (3) @(negedge clk);
        chk("cnt0_done_hold", reading_done, 1'b1);
        enable_reading = 1'b0;
        @(negedge clk); #1;
        chk("cnt0_done_clr", reading_done, 1'b0);
        chk("cnt0_no_req", n_iss, 0);
        chk("cnt0_no_words", cap_data.size(), 0);

        run_xfer("basic", 23'h000100, 24'd3, 100, 1, 100, 0);
        run_xfer("wrap", 23'h7FFFFE, 24'd4, 100, 1, 100, 0);
        run_xfer("stall", 23'h002000, 24'd20, 100, 30, 100, 150);

        // Abort after 5 acks with 3 returns.
        wait_quiet("abort");
        clear_env();
        ack_limit = 5; ret_limit = 3;
        ack_pct = 100; ret_delay = 2; tready_pct = 100;
        @(negedge clk);
        ddr3_rd_start_addr = 23'h000200;
        ddr3_rd_burst_cnt = 24'd10;
        enable_reading = 1'b1;
        k = 0;
        while (!(n_iss == 5 && n_ret == 3) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_acks", n_iss, 5);
        chk("abort_rets", n_ret, 3);
        enable_reading = 1'b0;
        #1;
        chk("abort_req_drop", mem_rd_req, 1'b0);
        chk("abort_tvalid_drop", m_tvalid, 1'b0);
        ncap = cap_data.size();
        ret_limit = 32'h3FFF_FFFF;
        ack_limit = 32'h3FFF_FFFF;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_all_returned", n_ret, 5);
        chk("abort_no_beats", cap_data.size(), ncap);
        chk("abort_no_done", done_seen, 1'b0);
        chk("abort_req_idle", mem_rd_req, 1'b0);
        run_xfer("after_abort", 23'h000300, 24'd1, 100, 1, 100, 0);

        // Reset in the middle of a streaming transfer; late returns must be ignored.
        wait_quiet("midrst");
        clear_env();
        ack_pct = 100; ret_delay = 2; tready_pct = 100;
        @(negedge clk);
        ddr3_rd_start_addr = 23'h001000;
        ddr3_rd_burst_cnt = 24'd20;
        enable_reading = 1'b1;
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_req", mem_rd_req, 1'b0);
        chk("midrst_tvalid", m_tvalid, 1'b0);
        chk("midrst_tlast", m_tlast, 1'b0);
        chk("midrst_done", reading_done, 1'b0);
        chk("midrst_addr", mem_rd_addr, 23'd0);
        chk("midrst_tdata", m_tdata, 32'd0);
        repeat (3) @(negedge clk);
        enable_reading = 1'b0;
        reset_n = 1'b1;
        run_xfer("post_rst", 23'h0ABCDE, 24'd2, 100, 1, 100, 0);

        for (int t = 0; t < 5; t++) begin
            run_xfer($sformatf("rand%0d", t), 23'($urandom), 24'($urandom_range(12, 1)),
                     50, int'($urandom_range(6, 1)), 50, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
